// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding with load-use stall control.
// Ports: CLK, RST_n, id_valid, rs, rf_data, pre_*, ppre_*, fwd_data, fwd_sel,
//   stall, bubble. Optional macro FWD_LINK_EN forwards link (PC+4) results.
module fwd_hazard_unit #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                      CLK,
  input  logic                      RST_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] rs,
  input  logic [NUM_SRC*XLEN-1:0]   rf_data,
  input  logic                      pre_valid,
  input  logic                      pre_regwr,
  input  logic [1:0]                pre_regdst,
  input  logic [REG_AW-1:0]         pre_rd,
  input  logic [XLEN-1:0]           pre_alu,
  input  logic [XLEN-1:0]           pre_pc4,
  input  logic                      pre_cmp,
  input  logic                      ppre_valid,
  input  logic                      ppre_regwr,
  input  logic [1:0]                ppre_regdst,
  input  logic [REG_AW-1:0]         ppre_rd,
  input  logic [XLEN-1:0]           ppre_alu,
  input  logic [XLEN-1:0]           ppre_pc4,
  input  logic                      ppre_cmp,
  input  logic [XLEN-1:0]           ppre_mem,
  output logic [NUM_SRC*XLEN-1:0]   fwd_data,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

  logic [NUM_SRC*XLEN-1:0] sel_data;
  logic [NUM_SRC*2-1:0]    sel_src;
  logic [NUM_SRC-1:0]      ld_use;
  logic                    hazard;

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;

`ifndef FWD_LINK_EN
  logic unused_pc4;
  assign unused_pc4 = ^{pre_pc4, ppre_pc4};
`endif

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    logic [REG_AW-1:0] r;
    logic              pre_hit, ppre_hit;
    logic              pre_ok, ppre_ok;
    logic [XLEN-1:0]   pre_val, ppre_val;
    logic [XLEN-1:0]   d;
    logic [1:0]        s;

    assign r = rs[i*REG_AW +: REG_AW];

    assign pre_hit = pre_valid & pre_regwr &
                     (pre_rd == r) & (r != '0);
    assign ppre_hit = ppre_valid & ppre_regwr &
                      (ppre_rd == r) & (r != '0);

    // A load still in EX/MEM has no data yet: it stalls instead.
    assign ld_use[i] = pre_hit & (pre_regdst == 2'b01);

    always_comb begin
      pre_ok  = pre_hit;
      pre_val = pre_alu;
      case (pre_regdst)
        2'b00: pre_val = pre_alu;
        2'b01: pre_ok  = 1'b0;
`ifdef FWD_LINK_EN
        2'b10: pre_val = pre_pc4;
`else
        2'b10: pre_ok  = 1'b0;
`endif
        2'b11: pre_val = {{(XLEN-1){1'b0}}, pre_cmp};
        default: pre_ok = 1'b0;
      endcase
    end

    always_comb begin
      ppre_ok  = ppre_hit;
      ppre_val = ppre_alu;
      case (ppre_regdst)
        2'b00: ppre_val = ppre_alu;
        2'b01: ppre_val = ppre_mem;
`ifdef FWD_LINK_EN
        2'b10: ppre_val = ppre_pc4;
`else
        2'b10: ppre_ok  = 1'b0;
`endif
        2'b11: ppre_val = {{(XLEN-1){1'b0}}, ppre_cmp};
        default: ppre_ok = 1'b0;
      endcase
    end

    always_comb begin
      d = rf_data[i*XLEN +: XLEN];
      s = 2'b00;
      if (pre_ok) begin
        d = pre_val;
        s = 2'b01;
      end else if (ppre_ok) begin
        d = ppre_val;
        s = 2'b10;
      end
    end

    assign sel_data[i*XLEN +: XLEN] = d;
    assign sel_src[i*2 +: 2]        = s;
  end

  assign hazard = id_valid & (|ld_use);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_RUN: begin
        if (hazard && LOAD_LAT > 1) begin
          state_nx = S_WAIT;
          cnt_nx   = CNT_INIT;
        end
      end
      S_WAIT: begin
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  // Gated by reset so a pending hazard cannot show during reset.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_RUN:   stall = hazard;
      S_WAIT:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
    stall  = stall & RST_n;
    bubble = stall;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      fwd_data <= '0;
      fwd_sel  <= '0;
    end else if (bubble) begin
      fwd_data <= '0;
      fwd_sel  <= '0;
    end else begin
      fwd_data <= sel_data;
      fwd_sel  <= sel_src;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit.
// Random and directed stimulus against a stall-counter reference model.
module tb_fwd_hazard_unit;
  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int AW   = 5;
  localparam int LL   = 3;
`ifdef FWD_LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_n;
  logic id_valid;
  logic [NS*AW-1:0] rs;
  logic [NS*XLEN-1:0] rf_data;
  logic pre_valid, pre_regwr, pre_cmp;
  logic [1:0] pre_regdst;
  logic [AW-1:0] pre_rd;
  logic [XLEN-1:0] pre_alu, pre_pc4;
  logic ppre_valid, ppre_regwr, ppre_cmp;
  logic [1:0] ppre_regdst;
  logic [AW-1:0] ppre_rd;
  logic [XLEN-1:0] ppre_alu, ppre_pc4, ppre_mem;
  logic [NS*XLEN-1:0] fwd_data;
  logic [NS*2-1:0] fwd_sel;
  logic stall, bubble;

  always #5 CLK = ~CLK;

  fwd_hazard_unit #(
    .XLEN(XLEN), .NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(LL)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .id_valid(id_valid),
    .rs(rs), .rf_data(rf_data),
    .pre_valid(pre_valid), .pre_regwr(pre_regwr),
    .pre_regdst(pre_regdst), .pre_rd(pre_rd),
    .pre_alu(pre_alu), .pre_pc4(pre_pc4), .pre_cmp(pre_cmp),
    .ppre_valid(ppre_valid), .ppre_regwr(ppre_regwr),
    .ppre_regdst(ppre_regdst), .ppre_rd(ppre_rd),
    .ppre_alu(ppre_alu), .ppre_pc4(ppre_pc4),
    .ppre_cmp(ppre_cmp), .ppre_mem(ppre_mem),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel),
    .stall(stall), .bubble(bubble)
  );

  typedef struct {
    logic st;
    logic [NS*XLEN-1:0] d;
    logic [NS*2-1:0] s;
  } exp_t;

  logic cq[$];
  exp_t rq[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int left = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [XLEN-1:0] pick(input logic [1:0] dst,
      input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem,
      input logic [XLEN-1:0] pc4, input logic cmp);
    case (dst)
      2'd0: return alu;
      2'd1: return mem;
      2'd2: return pc4;
      default: return XLEN'(cmp);
    endcase
  endfunction

  // Spec rules: x0 never forwarded, pre beats ppre beats RF,
  // pre loads and (without link) link writes are not forwardable.
  function automatic void ref_op(input int i,
      output logic [XLEN-1:0] v, output logic [1:0] s);
    logic [AW-1:0] r;
    r = rs[i*AW +: AW];
    v = rf_data[i*XLEN +: XLEN];
    s = 2'd0;
    if (r == 0) return;
    if (pre_valid && pre_regwr && pre_rd == r &&
        pre_regdst != 2'd1 && (LINK || pre_regdst != 2'd2)) begin
      s = 2'd1;
      v = pick(pre_regdst, pre_alu, '0, pre_pc4, pre_cmp);
      return;
    end
    if (ppre_valid && ppre_regwr && ppre_rd == r &&
        (LINK || ppre_regdst != 2'd2)) begin
      s = 2'd2;
      v = pick(ppre_regdst, ppre_alu, ppre_mem, ppre_pc4, ppre_cmp);
    end
  endfunction

  task automatic apply();
    bit hz;
    exp_t e;
    logic [XLEN-1:0] v;
    logic [1:0] s;
    logic [AW-1:0] r;
    hz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      r = rs[i*AW +: AW];
      if (id_valid && r != 0 && pre_valid && pre_regwr &&
          pre_rd == r && pre_regdst == 2'd1) hz = 1'b1;
    end
    if (left > 0) begin
      e.st = 1'b1;
      left--;
    end else if (hz) begin
      e.st = 1'b1;
      left = LL - 1;
    end else begin
      e.st = 1'b0;
    end
    e.d = '0;
    e.s = '0;
    if (!e.st) begin
      for (int i = 0; i < NS; i++) begin
        ref_op(i, v, s);
        e.d[i*XLEN +: XLEN] = v;
        e.s[i*2 +: 2] = s;
      end
    end
    cq.push_back(e.st);
    rq.push_back(e);
  endtask

  always @(negedge CLK) begin
    logic c;
    exp_t e;
    if (mon_en) begin
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("stall", {63'd0, stall}, {63'd0, c});
        chk("bubble", {63'd0, bubble}, {63'd0, c});
      end
      if (rq.size() > 1) begin
        e = rq.pop_front();
        chk("fwd_data", fwd_data, e.d);
        chk("fwd_sel", {60'd0, fwd_sel}, {60'd0, e.s});
      end
    end
  end

  task automatic clear();
    id_valid = 1'b0;
    rs = '0;
    rf_data = {$urandom, $urandom};
    pre_valid = 0; pre_regwr = 0; pre_regdst = 0; pre_rd = 0;
    pre_alu = 0; pre_pc4 = 0; pre_cmp = 0;
    ppre_valid = 0; ppre_regwr = 0; ppre_regdst = 0; ppre_rd = 0;
    ppre_alu = 0; ppre_pc4 = 0; ppre_cmp = 0; ppre_mem = 0;
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
    clear();
  endtask

  task automatic set_pre(input logic [1:0] dst, input logic [AW-1:0] rd);
    pre_valid = 1; pre_regwr = 1; pre_regdst = dst; pre_rd = rd;
  endtask

  task automatic set_ppre(input logic [1:0] dst, input logic [AW-1:0] rd);
    ppre_valid = 1; ppre_regwr = 1; ppre_regdst = dst; ppre_rd = rd;
  endtask

  initial begin
    clear();
    RST_n = 1'b0;
    #23;
    chk("rst_data", fwd_data, 64'd0);
    chk("rst_sel", {60'd0, fwd_sel}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    RST_n = 1'b1;

    // ALU forward from pre
    next(); id_valid = 1; set_pre(2'd0, 5); pre_alu = 32'h1234;
    rs = {5'd2, 5'd5}; apply(); mon_en = 1'b1;

    // pre and ppre both hit: pre wins
    next(); id_valid = 1; set_pre(2'd0, 7); set_ppre(2'd0, 7);
    pre_alu = 32'hA; ppre_alu = 32'hB; rs = {5'd7, 5'd7}; apply();

    // load-use on operand 1, then load data from ppre
    next(); id_valid = 1; set_pre(2'd1, 3); rs = {5'd3, 5'd1}; apply();
    for (int k = 1; k < LL; k++) begin
      next(); id_valid = 1; rs = {5'd3, 5'd1}; apply();
    end
    next(); id_valid = 1; set_ppre(2'd1, 3); ppre_mem = 32'hDEAD;
    rs = {5'd3, 5'd1}; apply();

    // x0 never forwarded, load to x0 never stalls
    next(); id_valid = 1; set_pre(2'd0, 0); pre_alu = 32'hFFFF;
    rs = {5'd0, 5'd0}; apply();
    next(); id_valid = 1; set_pre(2'd1, 0); rs = {5'd0, 5'd0}; apply();

    // compare bit from ppre, link from pre
    next(); id_valid = 1; set_ppre(2'd3, 9); ppre_cmp = 1;
    rs = {5'd1, 5'd9}; apply();
    next(); id_valid = 1; set_pre(2'd2, 9); pre_pc4 = 32'h40;
    rs = {5'd1, 5'd9}; apply();

    // pre load still stalls when ppre also matches
    next(); id_valid = 1; set_pre(2'd1, 4); set_ppre(2'd0, 4);
    rs = {5'd0, 5'd4}; apply();
    for (int k = 1; k < LL; k++) begin
      next(); apply();
    end

    // reset in first wait cycle
    next(); id_valid = 1; set_pre(2'd1, 6); rs = {5'd6, 5'd0}; apply();
    @(posedge CLK);
    #1;
    mon_en = 1'b0;
    cq.delete();
    rq.delete();
    chk("wait_stall", {63'd0, stall}, 64'd1);
    id_valid = 1'b0;
    RST_n = 1'b0;
    #1;
    chk("mid_rst_stall", {63'd0, stall}, 64'd0);
    chk("mid_rst_bubble", {63'd0, bubble}, 64'd0);
    chk("mid_rst_data", fwd_data, 64'd0);
    chk("mid_rst_sel", {60'd0, fwd_sel}, 64'd0);
    #1;
    RST_n = 1'b1;
    left = 0;
    #1;
    chk("post_rst_stall", {63'd0, stall}, 64'd0);
    next(); apply(); mon_en = 1'b1;
    next(); apply();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      next();
      id_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < NS; i++)
        rs[i*AW +: AW] = AW'($urandom_range(0, 7));
      pre_valid = 1'($urandom_range(0, 1));
      pre_regwr = 1'($urandom_range(0, 1));
      pre_regdst = 2'($urandom_range(0, 3));
      pre_rd = AW'($urandom_range(0, 7));
      pre_alu = $urandom; pre_pc4 = $urandom;
      pre_cmp = 1'($urandom_range(0, 1));
      ppre_valid = 1'($urandom_range(0, 1));
      ppre_regwr = 1'($urandom_range(0, 1));
      ppre_regdst = 2'($urandom_range(0, 3));
      ppre_rd = AW'($urandom_range(0, 7));
      ppre_alu = $urandom; ppre_pc4 = $urandom;
      ppre_mem = $urandom;
      ppre_cmp = 1'($urandom_range(0, 1));
      apply();
    end
    next(); apply();
    next(); apply();
    @(posedge CLK);
    #8;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
